// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: FSM encoding, 2-bit counter
// states and the saturating counter update.
package branch_predictor_pkg;

   // 2-bit saturating counter states
   localparam logic [1:0] CtrSnt = 2'b00;
   localparam logic [1:0] CtrWnt = 2'b01;
   localparam logic [1:0] CtrWt  = 2'b10;
   localparam logic [1:0] CtrSt  = 2'b11;

   // BTB clear walker states
   typedef enum logic {
      StIdle,
      StClear
   } bp_state_e;

   // Saturating increment on taken, saturating decrement otherwise
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CtrSt) ? CtrSt : ctr + 2'b01;
      end
      return (ctr == CtrSnt) ? CtrSnt : ctr - 2'b01;
   endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty does nothing; push+pop together replaces the top.
module bp_ras #(
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   input  logic        clear,
   output logic [31:0] top,
   output logic        empty
);

   localparam int unsigned PtrW = $clog2(RAS_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

   logic [31:0]     stack_q [RAS_DEPTH];
   logic [PtrW-1:0] ptr_q, ptr_d;   // next free slot
   logic [PtrW-1:0] top_ptr;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            wr_en;
   logic [PtrW-1:0] wr_ptr;

   assign top_ptr = ptr_q - PtrW'(1);
   assign empty   = (cnt_q == '0);
   assign top     = stack_q[top_ptr];

   // Pointer/count next state; clear wins over any push or pop
   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_ptr = ptr_q;
      if (clear) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (push && pop) begin
         wr_en  = 1'b1;
         wr_ptr = top_ptr;
      end else if (push) begin
         wr_en  = 1'b1;
         wr_ptr = ptr_q;
         ptr_d  = ptr_q + PtrW'(1);
         if (cnt_q != CntFull) begin
            cnt_d = cnt_q + CntW'(1);
         end
      end else if (pop && !empty) begin
         ptr_d = top_ptr;
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Stack storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else if (wr_en) begin
         stack_q[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit counters, a return-address
// stack serving JR $31 entries, and a one-entry-per-cycle BTB clear walker.
module branch_predictor #(
   parameter int unsigned ENTRIES   = 16,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] lk_addr,
   output logic        pred_taken,
   output logic [31:0] pred_addr,
   input  logic        upd_en,
   input  logic [31:0] upd_addr,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_call,
   input  logic        upd_ret,
   input  logic [31:0] ret_addr,
   input  logic        stall,
   input  logic        flush,
   output logic        busy
);

   import branch_predictor_pkg::*;

   localparam int unsigned IdxW = $clog2(ENTRIES);
   localparam int unsigned TagW = 32 - IdxW - 2;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(ENTRIES - 1);

   // BTB storage
   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] is_ret_q;
   logic [TagW-1:0]    tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   // Clear walker
   bp_state_e       state_q, state_d;
   logic [IdxW-1:0] clr_idx_q, clr_idx_d;
   logic            clr_en;
   logic            ras_clear;

   // Lookup path
   logic [IdxW-1:0] lk_idx;
   logic [TagW-1:0] lk_tag;
   logic            lk_hit;
   logic            lk_is_ret;

   // Update path
   logic [IdxW-1:0] upd_idx;
   logic [TagW-1:0] upd_tag;
   logic            upd_go;
   logic            upd_hit;
   logic            wr_en;
   logic [1:0]      wr_ctr;
   logic [31:0]     wr_target;

   // RAS
   logic            ras_push;
   logic            ras_pop;
   logic [31:0]     ras_top;
   logic            ras_empty;

   // Word-offset bits never participate in indexing or tagging
   logic unused_offsets;
   assign unused_offsets = ^{lk_addr[1:0], upd_addr[1:0]};

   // Lookup: purely combinational from current state, no write bypass
   always_comb begin
      lk_idx     = lk_addr[IdxW+1:2];
      lk_tag     = lk_addr[31:IdxW+2];
      lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      lk_is_ret  = is_ret_q[lk_idx];
      // A return entry with nothing on the stack has no usable target
      pred_taken = lk_hit && ctr_q[lk_idx][1] && !busy && !(lk_is_ret && ras_empty);
      pred_addr  = '0;
      if (pred_taken) begin
         pred_addr = lk_is_ret ? ras_top : target_q[lk_idx];
      end
   end

   // Update decode: hits train the entry, taken misses allocate
   always_comb begin
      upd_idx   = upd_addr[IdxW+1:2];
      upd_tag   = upd_addr[31:IdxW+2];
      upd_go    = upd_en && !stall && !busy;
      upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      wr_en     = upd_go && (upd_hit || upd_taken);
      wr_ctr    = upd_hit ? ctr_next(ctr_q[upd_idx], upd_taken) : CtrWt;
      wr_target = (upd_hit && !upd_taken) ? target_q[upd_idx] : upd_target;
   end

   // RAS operations are not blocked by a BTB clear
   assign ras_push = upd_en && !stall && upd_call;
   assign ras_pop  = upd_en && !stall && upd_ret;

   // Clear walker next state; a flush seen during a clear is dropped
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      busy      = 1'b0;
      clr_en    = 1'b0;
      ras_clear = 1'b0;
      case (state_q)
         StIdle: begin
            if (flush) begin
               state_d   = StClear;
               clr_idx_d = '0;
               ras_clear = 1'b1;
            end
         end
         StClear: begin
            busy      = 1'b1;
            clr_en    = 1'b1;
            clr_idx_d = clr_idx_q + IdxW'(1);
            if (clr_idx_q == LastIdx) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear walker state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // BTB entry writes; update and clear never coincide since clear implies busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         is_ret_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CtrWnt;
         end
      end else begin
         if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= wr_target;
            ctr_q[upd_idx]    <= wr_ctr;
            is_ret_q[upd_idx] <= upd_ret;
         end
         if (clr_en) begin
            valid_q[clr_idx_q] <= 1'b0;
         end
      end
   end

   bp_ras #(
      .RAS_DEPTH(RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ras_push),
      .pop      (ras_pop),
      .push_data(ret_addr),
      .clear    (ras_clear),
      .top      (ras_top),
      .empty    (ras_empty)
   );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, RAS_DEPTH=4).
module tb_branch_predictor;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;
   localparam logic [31:0] Z = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lk_addr;
   logic        pred_taken;
   logic [31:0] pred_addr;
   logic        upd_en;
   logic [31:0] upd_addr;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_call;
   logic        upd_ret;
   logic [31:0] ret_addr;
   logic        stall;
   logic        flush;
   logic        busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        upd_en;
      logic [31:0] upd_addr;
      logic        upd_taken;
      logic [31:0] upd_target;
      logic        upd_call;
      logic        upd_ret;
      logic [31:0] ret_addr;
      logic        stall;
      logic [31:0] lk_addr;
      logic        exp_taken;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   branch_predictor #(
      .ENTRIES  (16),
      .RAS_DEPTH(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lk_addr   (lk_addr),
      .pred_taken(pred_taken),
      .pred_addr (pred_addr),
      .upd_en    (upd_en),
      .upd_addr  (upd_addr),
      .upd_taken (upd_taken),
      .upd_target(upd_target),
      .upd_call  (upd_call),
      .upd_ret   (upd_ret),
      .ret_addr  (ret_addr),
      .stall     (stall),
      .flush     (flush),
      .busy      (busy)
   );

   function automatic vec_t mk(input logic en, input logic [31:0] a, input logic tk,
                               input logic [31:0] tgt, input logic call, input logic ret,
                               input logic [31:0] ra, input logic st, input logic [31:0] lk,
                               input logic et, input logic [31:0] ea);
      vec_t v;
      v.upd_en = en; v.upd_addr = a; v.upd_taken = tk; v.upd_target = tgt;
      v.upd_call = call; v.upd_ret = ret; v.ret_addr = ra; v.stall = st;
      v.lk_addr = lk; v.exp_taken = et; v.exp_addr = ea;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      upd_en = 1'b0; upd_addr = '0; upd_taken = 1'b0; upd_target = '0;
      upd_call = 1'b0; upd_ret = 1'b0; ret_addr = '0; stall = 1'b0; flush = 1'b0;
   endtask

   // Allocate a taken entry in every BTB slot: 0x1000+4i -> 0x2000+4i
   task automatic fill_all();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         clear_inputs();
         upd_en = 1'b1; upd_taken = 1'b1;
         upd_addr = 32'h1000 + 32'(i << 2);
         upd_target = 32'h2000 + 32'(i << 2);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   // Count slots whose lookup predicts the fill target
   task automatic count_hits(output int hits);
      hits = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         lk_addr = 32'h1000 + 32'(i << 2);
         #1;
         if (pred_taken === 1'b1 && pred_addr === 32'h2000 + 32'(i << 2)) hits++;
      end
   endtask

   task automatic ras_op(input logic call, input logic ret, input logic [31:0] ra);
      @(negedge clk);
      clear_inputs();
      upd_en = 1'b1; upd_addr = 32'h304; upd_call = call; upd_ret = ret; ret_addr = ra;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      int busy_cnt;
      logic saw_pred;

      // BTB training, counter saturation, RAS behaviour
      vecs.push_back(mk(Y, 32'h40, Y, 32'h100, N, N, Z, N, 32'h40, N, Z));       // alloc, no bypass
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h40, Y, 32'h100));            // visible next cycle
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h80, N, Z));                  // same idx, other tag
      vecs.push_back(mk(Y, 32'h40, N, 32'h777, N, N, Z, N, 32'h40, Y, 32'h100)); // ctr 10 -> 01
      vecs.push_back(mk(Y, 32'h40, N, 32'h777, N, N, Z, N, 32'h40, N, Z));       // 01 -> 00
      vecs.push_back(mk(Y, 32'h40, N, 32'h777, N, N, Z, N, 32'h40, N, Z));       // 00 stays
      vecs.push_back(mk(Y, 32'h40, Y, 32'h100, N, N, Z, N, 32'h40, N, Z));       // 00 -> 01
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h40, N, Z));
      vecs.push_back(mk(Y, 32'h40, Y, 32'h140, N, N, Z, N, 32'h40, N, Z));       // 01 -> 10, new tgt
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h40, Y, 32'h140));
      vecs.push_back(mk(Y, 32'h40, Y, 32'h140, N, N, Z, N, 32'h40, Y, 32'h140)); // -> 11
      vecs.push_back(mk(Y, 32'h40, Y, 32'h140, N, N, Z, N, 32'h40, Y, 32'h140)); // 11 stays
      vecs.push_back(mk(Y, 32'h40, N, 32'h777, N, N, Z, N, 32'h40, Y, 32'h140)); // -> 10, tgt kept
      vecs.push_back(mk(Y, 32'h40, N, 32'h777, N, N, Z, N, 32'h40, Y, 32'h140)); // -> 01
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h40, N, Z));
      vecs.push_back(mk(Y, 32'h40, Y, 32'h180, N, N, Z, Y, 32'h40, N, Z));       // stalled update
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h40, N, Z));                  // still 01
      vecs.push_back(mk(Y, 32'h44, N, 32'h500, N, N, Z, N, 32'h44, N, Z));       // miss not-taken
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h44, N, Z));                  // not allocated
      vecs.push_back(mk(Y, 32'h200, Y, 32'h999, N, Y, Z, N, 32'h200, N, Z));     // JR $31 alloc
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h200, N, Z));                 // RAS empty
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h40, N, Z));                  // 0x40 evicted
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'h1234, N, 32'h200, N, Z));    // push 0x1234
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h200, Y, 32'h1234));
      vecs.push_back(mk(Y, 32'h304, N, Z, N, Y, Z, N, 32'h200, Y, 32'h1234));    // pop
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h200, N, Z));
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'h10, N, 32'h200, N, Z));      // 5 pushes
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'h20, N, 32'h200, Y, 32'h10));
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'h30, N, 32'h200, Y, 32'h20));
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'h40, N, 32'h200, Y, 32'h30));
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'h50, N, 32'h200, Y, 32'h40));
      vecs.push_back(mk(Y, 32'h304, N, Z, N, Y, Z, N, 32'h200, Y, 32'h50));      // 5 pops
      vecs.push_back(mk(Y, 32'h304, N, Z, N, Y, Z, N, 32'h200, Y, 32'h40));
      vecs.push_back(mk(Y, 32'h304, N, Z, N, Y, Z, N, 32'h200, Y, 32'h30));
      vecs.push_back(mk(Y, 32'h304, N, Z, N, Y, Z, N, 32'h200, Y, 32'h20));
      vecs.push_back(mk(Y, 32'h304, N, Z, N, Y, Z, N, 32'h200, N, Z));           // pop on empty
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h200, N, Z));
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'hAA, N, 32'h200, N, Z));      // push 0xAA
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, Y, 32'hBB, N, 32'h200, Y, 32'hAA)); // push+pop
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h200, Y, 32'hBB));
      vecs.push_back(mk(Y, 32'h304, N, Z, N, Y, Z, N, 32'h200, Y, 32'hBB));      // pop -> empty
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h200, N, Z));
      vecs.push_back(mk(Y, 32'h304, N, Z, Y, N, 32'hCC, Y, 32'h200, N, Z));      // stalled push
      vecs.push_back(mk(N, Z, N, Z, N, N, Z, N, 32'h200, N, Z));

      // Reset state
      clear_inputs();
      rst_n = 1'b0;
      lk_addr = 32'h40;
      #1;
      check("reset busy", {31'b0, busy}, Z);
      check("reset pred_taken", {31'b0, pred_taken}, Z);
      check("reset pred_addr", pred_addr, Z);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         upd_en = vecs[i].upd_en; upd_addr = vecs[i].upd_addr;
         upd_taken = vecs[i].upd_taken; upd_target = vecs[i].upd_target;
         upd_call = vecs[i].upd_call; upd_ret = vecs[i].upd_ret;
         ret_addr = vecs[i].ret_addr; stall = vecs[i].stall; flush = 1'b0;
         lk_addr = vecs[i].lk_addr;
         #1;
         check($sformatf("row%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].exp_taken});
         check($sformatf("row%0d pred_addr", i), pred_addr, vecs[i].exp_addr);
         check($sformatf("row%0d busy", i), {31'b0, busy}, Z);
      end
      @(negedge clk);
      clear_inputs();

      // Flush with a full BTB: 16 busy cycles, updates and re-flush ignored
      fill_all();
      count_hits(hits);
      check("fill hits", 32'(hits), 32'd16);
      ras_op(Y, N, 32'hDD);
      ras_op(Y, N, 32'hEE);
      @(negedge clk);
      clear_inputs();
      flush = 1'b1;
      #1;
      check("flush cycle busy", {31'b0, busy}, Z);
      busy_cnt = 0;
      saw_pred = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         clear_inputs();
         lk_addr = 32'h1000;
         #1;
         if (busy !== 1'b1) break;
         busy_cnt++;
         upd_en = 1'b1; upd_addr = 32'h3000; upd_taken = 1'b1; upd_target = 32'h4000;
         flush = (busy_cnt == 3);
         #1;
         if (pred_taken !== 1'b0) saw_pred = 1'b1;
      end
      check("clear busy cycles", 32'(busy_cnt), 32'd16);
      check("pred during clear", {31'b0, saw_pred}, Z);
      clear_inputs();
      count_hits(hits);
      check("hits after clear", 32'(hits), Z);
      @(negedge clk);
      lk_addr = 32'h3000;
      #1;
      check("update during clear", {31'b0, pred_taken}, Z);
      // RAS must have been emptied by the flush: a pop now leaves nothing
      @(negedge clk);
      clear_inputs();
      upd_en = 1'b1; upd_addr = 32'h200; upd_taken = 1'b1; upd_target = 32'h999; upd_ret = 1'b1;
      @(negedge clk);
      clear_inputs();
      lk_addr = 32'h200;
      #1;
      check("RAS emptied by flush", {31'b0, pred_taken}, Z);

      // Reset in the middle of a clear
      fill_all();
      @(negedge clk);
      flush = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         clear_inputs();
      end
      lk_addr = 32'h1028;
      #1;
      check("busy before reset", {31'b0, busy}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("busy at reset", {31'b0, busy}, Z);
      check("pred at reset", {31'b0, pred_taken}, Z);
      @(negedge clk);
      rst_n = 1'b1;
      count_hits(hits);
      check("hits after reset", 32'(hits), Z);
      check("busy after reset", {31'b0, busy}, Z);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning number of BTB entries (power of two, 4..256).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack depth (power of two, 2..16).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port lk_addr  in  32  fetch PC for lookup.
REQ-006 SHALL have port pred_taken  out  1  predict redirect for lk_addr.
REQ-007 SHALL have port pred_addr  out  32  predicted target; 0 when pred_taken=0.
REQ-008 SHALL have port upd_en  in  1  ID-stage resolution valid this cycle.
REQ-009 SHALL have port upd_addr  in  32  PC of resolved branch/jump.
REQ-010 SHALL have port upd_taken  in  1  resolved branch_flag.
REQ-011 SHALL have port upd_target  in  32  resolved branch_addr.
REQ-012 SHALL have port upd_call  in  1  resolved instruction is JAL/JALR/BLTZAL/BGEZAL-taken (push).
REQ-013 SHALL have port upd_ret  in  1  resolved instruction is JR $31 (pop).
REQ-014 SHALL have port ret_addr  in  32  link value to push when upd_call.
REQ-015 SHALL have port stall  in  1  pipeline stall; update inputs ignored while high.
REQ-016 SHALL have port flush  in  1  one-cycle pulse starting a full BTB clear.
REQ-017 SHALL have port busy  out  1  high while a clear is in progress.

Function
REQ-018 SHALL index BTB with idx=lk_addr[log2(ENTRIES)+1:2], tag=lk_addr[31:log2(ENTRIES)+2]; entry = {valid, tag, target[31:0], ctr[1:0], is_ret}.
REQ-019 SHALL compute lookup combinationally from current state: hit = valid & tag match; pred_taken = hit & ctr[1] & ~busy.
REQ-020 SHALL drive pred_addr = RAS top when hit & is_ret & RAS non-empty, else stored target; pred_taken forced 0 when is_ret & RAS empty.
REQ-021 SHALL, on upd_en & ~stall & ~busy with tag hit: ctr saturating ++ on upd_taken, -- otherwise; target overwritten with upd_target on upd_taken; is_ret <= upd_ret.
REQ-022 SHALL, on upd_en & ~stall & ~busy with miss and upd_taken: allocate entry, valid=1, ctr=2'b10, target=upd_target, is_ret=upd_ret; miss and not-taken: no write.
REQ-023 SHALL make a write visible to lookup one cycle later; same-cycle lookup of the written index returns old contents (no bypass).
REQ-024 SHALL push ret_addr on upd_call, pop on upd_ret (both gated by upd_en & ~stall); push+pop same cycle replaces top, count unchanged.
REQ-025 SHALL on push when full overwrite oldest (circular pointer wrap, count stays RAS_DEPTH); pop when empty is a no-op.
REQ-026 SHALL FSM states IDLE, CLEAR; IDLE->CLEAR on flush; CLEAR walks counter 0..ENTRIES-1 invalidating one entry per cycle, ->IDLE after index ENTRIES-1; busy=1 exactly ENTRIES cycles.
REQ-027 SHALL ignore flush while in CLEAR; RAS SHALL be emptied in the flush cycle.

Reset
REQ-028 SHALL on rst_n=0 immediately: all valid=0, ctr=2'b01, RAS empty, FSM=IDLE, busy=0, pred_taken=0, pred_addr=0; reset mid-CLEAR aborts to IDLE.

Structure
REQ-029 SHALL place FSM state encodings, counter constants (SNT=00,WNT=01,WT=10,ST=11) in shared header bp.v alongside bus.v.
REQ-030 SHALL implement RAS as sub-module bp_ras (push, pop, top, empty, clear), parametrised by RAS_DEPTH.

Verification (ENTRIES=16, RAS_DEPTH=4)
REQ-031 SHALL cover: update 0x40 taken->0x100, next cycle lookup 0x40 -> pred_taken=1, pred_addr=0x100; lookup 0x80 (same idx, different tag) -> 0.
REQ-032 SHALL cover: after alloc, three not-taken updates of 0x40 -> ctr 10,01,00,00; pred_taken=0 after first.
REQ-033 SHALL cover: push 0x10,0x20,0x30,0x40,0x50 then 5 pops -> tops 0x50,0x40,0x30,0x20, then empty; 5th pop no-op.
REQ-034 SHALL cover: JR $31 entry at 0x200 allocated, push 0x1234 -> lookup 0x200 gives pred_addr=0x1234; RAS empty -> pred_taken=0.
REQ-035 SHALL cover: flush with 16 valid entries -> busy high 16 cycles, updates ignored, all lookups miss afterwards.
REQ-036 SHALL cover: rst_n low at clear cycle 5 -> busy=0 immediately, all entries invalid after release.
